// File: rtl/prim_esc_pkg.sv
// prim_esc_pkg: differential escalation line types and the responder FSM states.
package prim_esc_pkg;

  typedef struct packed {
    logic esc_p;
    logic esc_n;
  } esc_tx_t;

  typedef struct packed {
    logic resp_p;
    logic resp_n;
  } esc_rx_t;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Check   = 2'd1,
    EscResp = 2'd2,
    SigInt  = 2'd3
  } esc_resp_state_e;

endpackage

// File: rtl/esc_ping_watchdog.sv
// esc_ping_watchdog: arms on the first ping, counts Idle cycles and latches a sticky timeout.
module esc_ping_watchdog #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ping,
  input  logic idle,
  input  logic clr,
  output logic timeout
);
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(TimeoutCycles);
  localparam bit En = TimeoutCycles > 0;
  logic arm_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  // With the watchdog disabled MaxCnt is 0, so the counter never moves.
  always_comb cnt_d = clr ? '0 : ((arm_q | ping) & idle & (cnt_q != MaxCnt)) ? cnt_q + CntW'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arm_q   <= 1'b0;
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      arm_q   <= arm_q | ping;
      cnt_q   <= cnt_d;
      timeout <= timeout | (En && cnt_d == MaxCnt);
    end
  end
endmodule

// File: rtl/esc_responder.sv
// esc_responder: classifies the differential escalation line into ping, escalation or
// integrity fault, answers on the response pair and raises a local escalation request.
module esc_responder
  import prim_esc_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  esc_tx_t esc_tx_i,
  output esc_rx_t esc_rx_o,
  output logic    esc_req_o,
  output logic    ping_o,
  output logic    integ_fail_o,
  output logic    timeout_o
);
  esc_resp_state_e state_q, state_d;
  logic active, idle_line, integ_err, ping_d, resp_p_d, resp_n_d;
  logic resp_p_q, resp_n_q, req_q, ping_q, integ_q, timeout;
  always_comb begin
    active    = esc_tx_i.esc_p & ~esc_tx_i.esc_n;
    idle_line = ~esc_tx_i.esc_p & esc_tx_i.esc_n;
    integ_err = esc_tx_i.esc_p == esc_tx_i.esc_n;
    state_d   = state_q;
    ping_d    = 1'b0;
    unique case (state_q)
      Idle:    state_d = active ? Check : Idle;
      Check: begin
        state_d = active ? EscResp : Idle;
        ping_d  = idle_line;
      end
      EscResp: state_d = idle_line ? Idle : EscResp;
      SigInt:  state_d = active ? Check : idle_line ? Idle : SigInt;
      default: state_d = Idle;
    endcase
    // Integrity errors override every other transition.
    state_d  = integ_err ? SigInt : state_d;
    resp_p_d = (state_d == Check) |
               ((state_d == EscResp || state_d == SigInt) && state_d == state_q && !resp_p_q);
    // In SigInt the pair is deliberately equal so the sender sees the fault.
    resp_n_d = (state_d == SigInt) ? resp_p_d : !resp_p_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= Idle;
      resp_p_q <= 1'b0;
      resp_n_q <= 1'b1;
      req_q    <= 1'b0;
      ping_q   <= 1'b0;
      integ_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      resp_p_q <= resp_p_d;
      resp_n_q <= resp_n_d;
      req_q    <= state_d == EscResp || state_d == SigInt;
      ping_q   <= ping_d;
      integ_q  <= state_d == SigInt;
    end
  end
  esc_ping_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_wdog (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ping   (ping_q),
    .idle   (state_q == Idle),
    .clr    (state_q == Check),
    .timeout(timeout)
  );
  assign esc_rx_o.resp_p = resp_p_q;
  assign esc_rx_o.resp_n = resp_n_q;
  assign esc_req_o       = req_q | timeout;
  assign ping_o          = ping_q;
  assign integ_fail_o    = integ_q;
  assign timeout_o       = timeout;
endmodule

// File: tb/tb_esc_responder.sv
// tb_esc_responder: directed checks of ping, escalation, integrity, watchdog and async reset.
module tb_esc_responder;
  import prim_esc_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  esc_tx_t tx;
  esc_rx_t rx;
  logic req, ping, integ, tmo;
  logic [5:0] obs;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  esc_responder #(
    .TimeoutCycles(16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .esc_tx_i    (tx),
    .esc_rx_o    (rx),
    .esc_req_o   (req),
    .ping_o      (ping),
    .integ_fail_o(integ),
    .timeout_o   (tmo)
  );
  // {resp_p, resp_n, esc_req, ping, integ_fail, timeout}
  assign obs = {rx.resp_p, rx.resp_n, req, ping, integ, tmo};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic p, input logic n);
    tx.esc_p = p;
    tx.esc_n = n;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1);
    step();
    step();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs !== 6'b01_0000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got=%b exp=%b", i, obs, 6'b01_0000);
      end
    end
  endtask
  task automatic test_ping();
    do_reset();
    drive(1'b1, 1'b0);
    step();
    checks++;
    if (obs !== 6'b10_0000) begin errors++; $display("FAIL ping_check got=%b exp=%b", obs, 6'b10_0000); end
    drive(1'b0, 1'b1);
    step();
    checks++;
    if (obs !== 6'b01_0100) begin errors++; $display("FAIL ping_pulse got=%b exp=%b", obs, 6'b01_0100); end
    step();
    checks++;
    if (obs !== 6'b01_0000) begin errors++; $display("FAIL ping_end got=%b exp=%b", obs, 6'b01_0000); end
  endtask
  task automatic test_escalation();
    logic rp;
    logic [5:0] exp;
    do_reset();
    drive(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      rp = (i % 2) == 0;
      exp = {rp, ~rp, (i >= 1), 3'b000};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL esc cycle %0d got=%b exp=%b", i, obs, exp); end
    end
    drive(1'b0, 1'b1);
    step();
    checks++;
    if (obs !== 6'b01_0000) begin errors++; $display("FAIL esc_release got=%b exp=%b", obs, 6'b01_0000); end
  endtask
  task automatic test_sigint();
    logic rp;
    logic [5:0] exp;
    do_reset();
    drive(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      rp = (i % 2) == 1;
      exp = {rp, rp, 1'b1, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL sigint cycle %0d got=%b exp=%b", i, obs, exp); end
    end
    drive(1'b0, 1'b1);
    step();
    checks++;
    if (obs !== 6'b01_0000) begin errors++; $display("FAIL sigint_exit got=%b exp=%b", obs, 6'b01_0000); end
  endtask
  task automatic test_timeout();
    do_reset();
    drive(1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1);
    step();
    checks++;
    if (obs !== 6'b01_0100) begin errors++; $display("FAIL tmo_ping got=%b exp=%b", obs, 6'b01_0100); end
    repeat (15) step();
    checks++;
    if (obs !== 6'b01_0000) begin errors++; $display("FAIL tmo_before got=%b exp=%b", obs, 6'b01_0000); end
    step();
    checks++;
    if (obs !== 6'b01_1001) begin errors++; $display("FAIL tmo_set got=%b exp=%b", obs, 6'b01_1001); end
    drive(1'b1, 1'b0);
    step();
    checks++;
    if (obs !== 6'b10_1001) begin errors++; $display("FAIL tmo_sticky_check got=%b exp=%b", obs, 6'b10_1001); end
    drive(1'b0, 1'b1);
    step();
    checks++;
    if (obs !== 6'b01_1101) begin errors++; $display("FAIL tmo_sticky_ping got=%b exp=%b", obs, 6'b01_1101); end
    repeat (5) step();
    checks++;
    if (obs !== 6'b01_1001) begin errors++; $display("FAIL tmo_sticky_idle got=%b exp=%b", obs, 6'b01_1001); end
  endtask
  task automatic test_no_timeout();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0);
      step();
      drive(1'b0, 1'b1);
      step();
      checks++;
      if (obs !== 6'b01_0100) begin errors++; $display("FAIL periodic_ping %0d got=%b exp=%b", k, obs, 6'b01_0100); end
      repeat (8) step();
    end
    checks++;
    if (obs !== 6'b01_0000) begin errors++; $display("FAIL periodic_end got=%b exp=%b", obs, 6'b01_0000); end
  endtask
  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1);
    step();
    repeat (16) step();
    checks++;
    if (obs !== 6'b01_1001) begin errors++; $display("FAIL arst_pre_tmo got=%b exp=%b", obs, 6'b01_1001); end
    drive(1'b1, 1'b0);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b01_0000) begin errors++; $display("FAIL arst_escresp got=%b exp=%b", obs, 6'b01_0000); end
    drive(1'b0, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 1'b1);
    step();
    step();
    checks++;
    if (obs !== 6'b11_1010) begin errors++; $display("FAIL arst_pre_sigint got=%b exp=%b", obs, 6'b11_1010); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b01_0000) begin errors++; $display("FAIL arst_sigint got=%b exp=%b", obs, 6'b01_0000); end
    drive(1'b0, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 1'b0);
    step();
    checks++;
    if (obs !== 6'b10_0000) begin errors++; $display("FAIL arst_ping_check got=%b exp=%b", obs, 6'b10_0000); end
    drive(1'b0, 1'b1);
    step();
    checks++;
    if (obs !== 6'b01_0100) begin errors++; $display("FAIL arst_ping_pulse got=%b exp=%b", obs, 6'b01_0100); end
  endtask
  initial begin
    drive(1'b0, 1'b1);
    test_reset();
    test_ping();
    test_escalation();
    test_sigint();
    test_timeout();
    test_no_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
